// File: rtl/load_extend_unit_if.sv
// load_extend_unit_if
//   Carries both handshake sides of the load extender.
//   Request side:  in_valid/in_ready plus the raw word, offset, size and signedness.
//   Response side: out_valid/out_ready plus the extended data and the error flags.
//   master modport: the environment (memory read path and write-back consumer).
//   slave modport:  the load_extend_unit itself.
interface load_extend_unit_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_word;
  logic [OFF_W-1:0]  in_offset;
  logic [1:0]        in_size;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;
  logic              out_bad_size;

  modport master (
    output in_valid, in_word, in_offset, in_size, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_misalign, out_bad_size
  );

  modport slave (
    input  in_valid, in_word, in_offset, in_size, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_misalign, out_bad_size
  );
endinterface

// File: rtl/load_extend_unit.sv
// load_extend_unit
//   Picks a byte, halfword or word out of a memory read word using the byte
//   offset, sign- or zero-extends it to DATA_W and queues the result in a
//   2-entry output buffer. Misaligned and illegal-size requests produce zero
//   data with a flag; misaligned accepts bump a saturating counter.
// Ports
//   Clk            rising-edge clock
//   Reset          synchronous active-high reset
//   bus            request/response handshakes (slave side)
//   misalign_count saturating count of accepted misaligned requests
module load_extend_unit #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  load_extend_unit_if.slave    bus,
  output logic [CNT_W-1:0]     misalign_count
);

  logic [DATA_W-1:0] w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic              w_misalign;
  logic              w_bad;
  logic              w_push;
  logic              w_pop;

  // Entry 0 is always the head; entry 1 only holds data when r_count == 2.
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_mis0, r_mis1;
  logic              r_bad0, r_bad1;
  logic [1:0]        r_count;
  logic [CNT_W-1:0]  r_misalign_count;

  // Moving the addressed lane down to bit 0 makes byte and half selection a
  // fixed slice regardless of DATA_W.
  assign w_shifted = bus.in_word >> {bus.in_offset, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    w_ext      = '0;
    w_misalign = 1'b0;
    w_bad      = 1'b0;
    case (bus.in_size)
      2'b00: begin
        // Fill every bit with the extension value, then overlay the field;
        // avoids a zero-width replication when DATA_W is 16.
        w_ext      = {DATA_W{bus.in_signed & w_byte[7]}};
        w_ext[7:0] = w_byte;
      end
      2'b01: begin
        if (bus.in_offset[0]) begin
          w_misalign = 1'b1;
        end else begin
          w_ext       = {DATA_W{bus.in_signed & w_half[15]}};
          w_ext[15:0] = w_half;
        end
      end
      2'b10: begin
        if (bus.in_offset != '0) w_misalign = 1'b1;
        else                     w_ext      = bus.in_word;
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign bus.in_ready     = (r_count != 2'd2);
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.out_data     = bus.out_valid ? r_data0 : '0;
  assign bus.out_misalign = bus.out_valid & r_mis0;
  assign bus.out_bad_size = bus.out_valid & r_bad0;
  assign misalign_count   = r_misalign_count;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_data0          <= '0;
      r_data1          <= '0;
      r_mis0           <= 1'b0;
      r_mis1           <= 1'b0;
      r_bad0           <= 1'b0;
      r_bad1           <= 1'b0;
      r_count          <= 2'd0;
      r_misalign_count <= '0;
    end else begin
      // Push and pop together can only happen at count 1 (count 2 blocks push).
      if (w_push && w_pop) begin
        r_data0 <= w_ext;
        r_mis0  <= w_misalign;
        r_bad0  <= w_bad;
      end else if (w_pop) begin
        r_data0 <= r_data1;
        r_mis0  <= r_mis1;
        r_bad0  <= r_bad1;
        r_data1 <= '0;
        r_mis1  <= 1'b0;
        r_bad1  <= 1'b0;
        r_count <= r_count - 2'd1;
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_data0 <= w_ext;
          r_mis0  <= w_misalign;
          r_bad0  <= w_bad;
        end else begin
          r_data1 <= w_ext;
          r_mis1  <= w_misalign;
          r_bad1  <= w_bad;
        end
        r_count <= r_count + 2'd1;
      end

      if (w_push && w_misalign && (r_misalign_count != {CNT_W{1'b1}}))
        r_misalign_count <= r_misalign_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  load_extend_unit_if #(.DATA_W(32), .OFF_W(2)) bus();
  load_extend_unit_if #(.DATA_W(32), .OFF_W(2)) bus2();
  logic [15:0] mcnt;
  logic [3:0]  mcnt2;

  load_extend_unit #(.DATA_W(32), .OFF_W(2), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave), .misalign_count(mcnt));

  load_extend_unit #(.DATA_W(32), .OFF_W(2), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave), .misalign_count(mcnt2));

  typedef struct {
    logic [31:0] data;
    bit          mis;
    bit          bad;
  } exp_t;

  exp_t        q[$];
  int unsigned mcount;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the memory word, 32-bit data, 4 lanes.
  function automatic exp_t ref_model(input logic [31:0] w, input int off, input int size, input bit sgn);
    exp_t e;
    longint v;
    e.data = 32'h0; e.mis = 0; e.bad = 0;
    case (size)
      0: begin
        v = (longint'(w) >> (8 * off)) & 255;
        if (sgn && v >= 128) v = v - 256;
        e.data = 32'(v);
      end
      1: begin
        if (off % 2 != 0) e.mis = 1;
        else begin
          v = (longint'(w) >> (8 * off)) & 65535;
          if (sgn && v >= 32768) v = v - 65536;
          e.data = 32'(v);
        end
      end
      2: begin
        if (off != 0) e.mis = 1;
        else e.data = w;
      end
      default: e.bad = 1;
    endcase
    return e;
  endfunction

  // One clock of the main DUT: drive, check pre-edge state against the model,
  // clock, update the model, check the counter.
  task automatic cycle(input bit rst, input bit v, input logic [31:0] w, input int off,
                       input int size, input bit sgn, input bit ordy);
    exp_t e, h;
    bit push, pop;
    Reset         = rst;
    bus.in_valid  = v;
    bus.in_word   = w;
    bus.in_offset = 2'(off);
    bus.in_size   = 2'(size);
    bus.in_signed = sgn;
    bus.out_ready = ordy;
    #1;
    h.data = 32'h0; h.mis = 0; h.bad = 0;
    if (q.size() > 0) h = q[0];
    check("in_ready",     32'(bus.in_ready),     32'(q.size() < 2));
    check("out_valid",    32'(bus.out_valid),    32'(q.size() > 0));
    check("out_data",     bus.out_data,          h.data);
    check("out_misalign", 32'(bus.out_misalign), 32'(h.mis));
    check("out_bad_size", 32'(bus.out_bad_size), 32'(h.bad));
    push = !rst && v && (q.size() < 2);
    pop  = !rst && ordy && (q.size() > 0);
    e = ref_model(w, off, size, sgn);
    @(posedge Clk); #1;
    if (rst) begin
      q.delete();
      mcount = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e.mis && mcount < 65535) mcount++;
      end
    end
    check("misalign_count", 32'(mcnt), 32'(mcount));
  endtask

  logic [31:0] lb_s[4];
  logic [31:0] lb_u[4];
  logic [31:0] head_hold;

  initial begin
    lb_s = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    lb_u = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
    Reset = 1'b1;
    bus.in_valid = 0; bus.in_word = 0; bus.in_offset = 0; bus.in_size = 0;
    bus.in_signed = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_word = 0; bus2.in_offset = 0; bus2.in_size = 0;
    bus2.in_signed = 0; bus2.out_ready = 1;
    mcount = 0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);

    // lb / lbu
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 32'h80FF7F01, k, 0, 1, 1);
      check("lb", bus.out_data, lb_s[k]);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 32'h80FF7F01, k, 0, 0, 1);
      check("lbu", bus.out_data, lb_u[k]);
    end

    // lh / lhu / lw
    cycle(0, 1, 32'h8001F00F, 0, 1, 1, 1);
    check("lh_off0", bus.out_data, 32'hFFFFF00F);
    cycle(0, 1, 32'h8001F00F, 2, 1, 0, 1);
    check("lhu_off2", bus.out_data, 32'h00008001);
    cycle(0, 1, 32'h8001F00F, 0, 2, 1, 1);
    check("lw", bus.out_data, 32'h8001F00F);

    // Misaligned and illegal size
    cycle(0, 1, 32'h8001F00F, 1, 1, 1, 1);
    check("mis_half_data", bus.out_data, 32'h0);
    check("mis_half_flag", 32'(bus.out_misalign), 32'h1);
    check("mis_half_cnt",  32'(mcnt), 32'd1);
    cycle(0, 1, 32'h8001F00F, 3, 2, 0, 1);
    check("mis_word_cnt",  32'(mcnt), 32'd2);
    cycle(0, 1, 32'h8001F00F, 0, 3, 0, 1);
    check("bad_flag", 32'(bus.out_bad_size), 32'h1);
    check("bad_mis",  32'(bus.out_misalign), 32'h0);
    check("bad_cnt",  32'(mcnt), 32'd2);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Back-pressure: three pushes with out_ready low, then drain
    cycle(0, 1, 32'h11223344, 1, 0, 0, 0);
    cycle(0, 1, 32'h11223344, 2, 1, 0, 0);
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    head_hold = bus.out_data;
    cycle(0, 1, 32'hCAFEBABE, 0, 2, 0, 0);
    check("bp_head_stable", bus.out_data, 32'h00000033);
    check("bp_head_hold",   bus.out_data, head_hold);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(0, 1'($urandom_range(0, 3) != 0), $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 7));
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);

    // Saturation with a 4-bit counter
    bus.out_ready = 0;
    bus2.in_valid = 1; bus2.in_word = 32'h12345678; bus2.in_offset = 2'd1;
    bus2.in_size = 2'b01; bus2.in_signed = 1; bus2.out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      check("sat_cnt", 32'(mcnt2), (i < 15) ? 32'(i) : 32'd15);
    end
    bus2.in_valid = 0;

    // Reset mid-operation with a full buffer and a request present
    cycle(0, 1, 32'h0000FFFF, 1, 1, 1, 0);
    cycle(0, 1, 32'h0000FFFF, 2, 2, 1, 0);
    check("pre_rst_full", 32'(bus.in_ready), 32'h0);
    cycle(1, 1, 32'hDEADBEEF, 0, 2, 0, 0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'h1);
    check("mid_rst_cnt",   32'(mcnt),          32'h0);
    check("mid_rst_sat",   32'(mcnt2),         32'h0);
    repeat (5) cycle(0, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
